pll_lock_supervisor: RTL

Controls the reset input of the 50→25 MHz PLL wrapper and consumes its locked output. It runs on the PLL reference clock, pulses the PLL reset, waits for lock with a timeout and bounded retries, and requires lock to be held stable before releasing the system reset for the derived clock domain. It re-runs the sequence whenever lock is lost. It enters a sticky FAIL state when retries are exhausted.

---
 rtl/pll_lock_supervisor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// pll_lock_supervisor: runs on the PLL reference clock. It pulses the PLL reset,
// waits for lock with a timeout and bounded retries, and qualifies lock stability
// before it releases the derived-domain reset. Any loss of lock restarts the
// sequence. The block ends in a sticky FAIL once the retries are exhausted.
// Build option PLL_SUPERVISOR_STATUS_EN: when defined, the block builds the
// lock-loss counter and drives the state_o status output. When undefined, both
// status outputs are tied to zero.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic [CNT_W-1:0] lock_lost_cnt,
    output logic [2:0]       state_o
);

    localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC) + 1;
    localparam int unsigned RW      = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [RW-1:0]   retry_inc;
    logic            sync1_q, sync2_q;
    logic            locked_s;
    logic            pll_rst_q, sys_rst_q, ready_q, fail_q;

    assign locked_s  = sync2_q;
    assign retry_inc = retry_q + RW'(1);

    // Two-flop synchronizer bringing the asynchronous PLL lock into refclk
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    // Next-state, cycle counter and retry bookkeeping
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + TW'(1);
        retry_d = retry_q;
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == TW'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RW'(MAX_RETRIES)) ? S_FAIL : S_RESET_PLL;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == TW'(STABLE_CYCLES - 1)) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!locked_s) state_d = S_RESET_PLL;
            end
            S_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // State register with registered Moore output decodes taken from the next state
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
            sys_rst_q <= (state_d != S_RUN);
            ready_q   <= (state_d == S_RUN);
            fail_q    <= (state_d == S_FAIL);
        end
    end

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign ready   = ready_q;
    assign fail    = fail_q;

`ifdef PLL_SUPERVISOR_STATUS_EN
    logic [CNT_W-1:0] lost_q, lost_d;

    // Saturating count of lock losses observed while running
    always_comb begin
        lost_d = lost_q;
        if ((state_q == S_RUN) && !locked_s && (lost_q != '1)) lost_d = lost_q + CNT_W'(1);
    end

    // Lock-loss counter register
    always_ff @(posedge refclk) begin
        if (rst) lost_q <= '0;
        else     lost_q <= lost_d;
    end

    assign lock_lost_cnt = lost_q;
    assign state_o       = state_q;
`else
    assign lock_lost_cnt = '0;
    assign state_o       = '0;
`endif

endmodule
